// File: rtl/serial_code_pkg.sv
// Shared definitions for the keypad-unlock serial code transmitter.
// Optional odd-parity trailer bit is enabled by defining SERIAL_CODE_PARITY_EN.
package serial_code_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND,
        GAP  = ST_GAP,
        DONE = ST_DONE
    } state_t;

    localparam logic [4:0] DEFAULT_CODE = 5'b01001;
    localparam logic       IDLE_LEVEL   = 1'b1;

`ifdef SERIAL_CODE_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Number of bits in one frame: the code plus an optional parity bit.
    function automatic int frame_len(input int code_w, input bit parity_en);
        return parity_en ? code_w + 1 : code_w;
    endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: tick marks the last clock cycle of each bit period.
// Holding clear forces the count back to the start of a period.
module serial_bit_timer #(
    parameter int BIT_CYC = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int              CNT_W    = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    // Count cycles within a bit period, wrapping after the last one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_code_tx.sv
// Bit-serial transmitter for the keypad-unlock code: sends the stored code
// MSB-first on a_out, optionally repeated with idle-high gaps between frames.
// Define SERIAL_CODE_PARITY_EN to append an odd-parity bit to each frame.
module serial_code_tx
    import serial_code_pkg::*;
#(
    parameter int                CODE_W       = 5,
    parameter logic [CODE_W-1:0] DEFAULT_CODE = CODE_W'(serial_code_pkg::DEFAULT_CODE),
    parameter int                BIT_CYC      = 4,
    parameter int                GAP_BITS     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              code_load,
    input  logic [CODE_W-1:0] code_in,
    input  logic [3:0]        repeat_n,
    output logic              a_out,
    output logic              busy,
    output logic              done
);

    localparam int FRAME_LEN = frame_len(CODE_W, PARITY_EN);
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int GAP_W     = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;

    localparam logic [IDX_W-1:0] IDX_MSB  = IDX_W'(FRAME_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_BITS - 1);

    state_t               state;
    logic [CODE_W-1:0]    code_reg;
    logic [CODE_W-1:0]    load_code;
    logic [FRAME_LEN-1:0] frame_reg;
    logic [FRAME_LEN-1:0] load_frame;
    logic [IDX_W-1:0]     idx;
    logic [GAP_W-1:0]     gap_cnt;
    logic [3:0]           rep_cnt;
    logic                 tick;
    logic                 timer_clear;
    logic                 accepting;

    assign accepting = (state == IDLE) || (state == DONE);

    // A load in the same cycle as start is forwarded into the frame.
    assign load_code = code_load ? code_in : code_reg;

    if (PARITY_EN) begin : g_parity
        assign load_frame = {load_code, ~^load_code};
    end else begin : g_no_parity
        assign load_frame = load_code;
    end

    // Holding the timer clear outside SEND/GAP means every SEND/GAP entry from
    // IDLE/DONE starts a fresh period; SEND<->GAP moves happen on a tick, where
    // the timer has just wrapped.
    assign timer_clear = accepting;

    serial_bit_timer #(
        .BIT_CYC (BIT_CYC)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (timer_clear),
        .tick  (tick)
    );

    assign a_out = (state == SEND) ? frame_reg[idx] : IDLE_LEVEL;
    assign busy  = (state == SEND) || (state == GAP);
    assign done  = (state == DONE);

    // Code register: writable only while no transmission is in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_reg <= DEFAULT_CODE;
        end else if (accepting && code_load) begin
            code_reg <= code_in;
        end
    end

    // Frame sequencing: bit index, gap length and repetition count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            frame_reg <= '0;
            idx       <= '0;
            gap_cnt   <= '0;
            rep_cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= SEND;
                        frame_reg <= load_frame;
                        idx       <= IDX_MSB;
                        rep_cnt   <= repeat_n;
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (idx == '0) begin
                            if (rep_cnt != 4'd0) begin
                                state   <= GAP;
                                rep_cnt <= rep_cnt - 1'b1;
                                gap_cnt <= '0;
                            end else begin
                                state <= DONE;
                            end
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (tick) begin
                        if (gap_cnt == GAP_LAST) begin
                            state <= SEND;
                            idx   <= IDX_MSB;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_code_tx.sv
// Self-checking bench for serial_code_tx (default parameters).
// Honours SERIAL_CODE_PARITY_EN the same way as the design.
module tb_serial_code_tx;

    localparam int         BIT_CYC  = 4;
    localparam int         GAP_BITS = 2;
    localparam logic [4:0] DEF_CODE = 5'b01001;
`ifdef SERIAL_CODE_PARITY_EN
    localparam int LAT_R0 = 25;
    localparam int LAT_R1 = 57;
    localparam int LAT_R2 = 89;
`else
    localparam int LAT_R0 = 21;
    localparam int LAT_R1 = 49;
    localparam int LAT_R2 = 77;
`endif

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic       code_load;
    logic [4:0] code_in;
    logic [3:0] repeat_n;
    logic       a_out;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model state: expected {a_out, busy, done} for this cycle and the future.
    logic [2:0] exp_cur;
    logic [2:0] exp_now;
    logic [2:0] exp_q[$];
    logic [4:0] mcode;
    logic       m_busy;

    int   done_cnt = 0;
    int   busy_cnt = 0;
    bit   rec      = 1'b0;
    logic rec_q[$];

    serial_code_tx dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .code_load (code_load),
        .code_in   (code_in),
        .repeat_n  (repeat_n),
        .a_out     (a_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Expected line activity for a whole transmission: R+1 frames MSB-first,
    // idle-high gaps between them, then a single done cycle.
    function automatic void pushFrames(input logic [4:0] c, input int r);
        for (int f = 0; f <= r; f++) begin
            for (int b = 4; b >= 0; b--)
                for (int k = 0; k < BIT_CYC; k++) exp_q.push_back({c[b], 1'b1, 1'b0});
`ifdef SERIAL_CODE_PARITY_EN
            for (int k = 0; k < BIT_CYC; k++) exp_q.push_back({~^c, 1'b1, 1'b0});
`endif
            if (f < r)
                for (int k = 0; k < GAP_BITS * BIT_CYC; k++) exp_q.push_back(3'b110);
        end
        exp_q.push_back(3'b101);
    endfunction

    // Transaction-level model: reacts to the inputs seen at each edge.
    always @(posedge clk) begin
        if (reset) begin
            exp_q.delete();
            mcode   = DEF_CODE;
            exp_cur = 3'b100;
        end else begin
            m_busy = exp_cur[1];
            if (m_busy && abort) begin
                exp_q.delete();
            end else if (!m_busy && start) begin
                exp_q.delete();
                pushFrames(code_load ? code_in : mcode, int'(repeat_n));
            end
            if (!m_busy && code_load) mcode = code_in;
            if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
            else                  exp_cur = 3'b100;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        exp_now = reset ? 3'b100 : exp_cur;
        checkOutput("model_a_out", a_out, exp_now[2]);
        checkOutput("model_busy",  busy,  exp_now[1]);
        checkOutput("model_done",  done,  exp_now[0]);
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (rec) rec_q.push_back(a_out);
    end

    task automatic applyStimulus(input logic s, input logic ab, input logic ld,
                                 input logic [4:0] ci, input logic [3:0] rn);
        start     = s;
        abort     = ab;
        code_load = ld;
        code_in   = ci;
        repeat_n  = rn;
        @(posedge clk);
        #1;
        start     = 1'b0;
        abort     = 1'b0;
        code_load = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitDone(input int limit, input string nm);
        int k = 0;
        while (done !== 1'b1 && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (done !== 1'b1) checkOutput(nm, done, 1);
    endtask

    // Called in the first cycle of a frame; samples each bit period.
    task automatic checkFrame(input logic [4:0] pat, input logic par, input string nm);
        logic [4:0] p;
        p = pat;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("%s_bit%0d", nm, i), a_out, p[4-i]);
            waitCycles(BIT_CYC);
        end
`ifdef SERIAL_CODE_PARITY_EN
        checkOutput($sformatf("%s_parity", nm), a_out, par);
        waitCycles(BIT_CYC);
`else
        if (par !== 1'bx) p = pat;
`endif
    endtask

    int         t0;
    int         dcnt;
    int         unlocks;
    logic [4:0] sr;

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        code_load = 1'b0;
        code_in   = '0;
        repeat_n  = '0;
        exp_cur   = 3'b100;
        mcode     = DEF_CODE;

        waitCycles(2);
        checkOutput("reset_a_out", a_out, 1);
        checkOutput("reset_busy",  busy,  0);
        checkOutput("reset_done",  done,  0);
        reset = 1'b0;
        waitCycles(2);

        // Basic frame, R=0, then a back-to-back start issued in DONE.
        t0 = cyc;
        busy_cnt = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00000, 4'd0);
        checkFrame(5'b01001, 1'b1, "basic");
        waitDone(40, "basic_done_timeout");
        checkOutput("basic_done_cycle", cyc - t0, LAT_R0);
        checkOutput("basic_busy_cycles", busy_cnt, LAT_R0 - 1);
        t0 = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00000, 4'd0);
        checkOutput("b2b_busy", busy, 1);
        checkFrame(5'b01001, 1'b1, "b2b");
        waitDone(40, "b2b_done_timeout");
        checkOutput("b2b_done_cycle", cyc - t0, LAT_R0);

        // Three frames with gaps; a reference detector counts unlocks.
        waitCycles(3);
        t0 = cyc;
        rec_q.delete();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00000, 4'd2);
        rec = 1'b1;
        waitDone(200, "repeat_done_timeout");
        rec = 1'b0;
        checkOutput("repeat_done_cycle", cyc - t0, LAT_R2);
        sr = 5'b11111;
        unlocks = 0;
        for (int k = 1; k < rec_q.size(); k += BIT_CYC) begin
            sr = {sr[3:0], rec_q[k]};
            if (sr == DEF_CODE) unlocks++;
        end
        checkOutput("repeat_unlocks", unlocks, 3);

        // Load forwarded into the frame, then a load while busy is ignored.
        waitCycles(2);
        t0 = cyc;
        applyStimulus(1'b1, 1'b0, 1'b1, 5'b10110, 4'd0);
        checkFrame(5'b10110, 1'b0, "load");
        waitDone(40, "load_done_timeout");
        checkOutput("load_done_cycle", cyc - t0, LAT_R0);
        waitCycles(1);
        t0 = cyc;
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00000, 4'd1);
        waitCycles(3);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'b00011, 4'd0);
        waitDone(100, "busyload_done_timeout");
        checkOutput("r1_done_cycle", cyc - t0, LAT_R1);
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00000, 4'd0);
        checkFrame(5'b10110, 1'b0, "after_busy_load");
        waitDone(40, "abl_done_timeout");

        // Abort sampled at the end of cycle 7, new start at cycle 10.
        waitCycles(2);
        t0 = cyc;
        dcnt = done_cnt;
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00000, 4'd0);
        waitCycles(6);
        applyStimulus(1'b0, 1'b1, 1'b0, 5'b00000, 4'd0);
        checkOutput("abort_cycle", cyc - t0, 8);
        checkOutput("abort_busy",  busy,  0);
        checkOutput("abort_a_out", a_out, 1);
        waitCycles(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00000, 4'd0);
        checkFrame(5'b10110, 1'b0, "after_abort");
        waitDone(40, "abort_done_timeout");
        @(negedge clk);
        #1;
        checkOutput("abort_done_pulses", done_cnt - dcnt, 1);
        waitCycles(1);

        // Start and abort together while idle: start takes effect.
        waitCycles(2);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'b00000, 4'd0);
        checkOutput("start_beats_abort", busy, 1);
        waitDone(40, "sba_done_timeout");

        // Asynchronous reset between edges during a 0 bit.
        waitCycles(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00000, 4'd0);
        waitCycles(5);
        checkOutput("pre_reset_a_out", a_out, 0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_a_out", a_out, 1);
        checkOutput("async_reset_busy",  busy,  0);
        checkOutput("async_reset_done",  done,  0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        waitCycles(1);
        applyStimulus(1'b1, 1'b0, 1'b0, 5'b00000, 4'd0);
        checkFrame(5'b01001, 1'b1, "post_reset");
        waitDone(40, "post_reset_done_timeout");
        waitCycles(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
